vga_bounce_box: RTL
===================

VGA_BOUNCE_BOX -- requirements
Module: vga_bounce_box

Interface
REQ-001 Parameter WIDTH, default 800, active columns.
REQ-002 Parameter HEIGHT, default 600, active rows.
REQ-003 Parameter BOX_SIZE, default 32, box edge length in pixels.
REQ-004 Parameter STEP, default 2, pixels moved per axis per frame.
REQ-005 Parameter BG_RGB, default 12'h000, background colour {r,g,b}.
REQ-006 clk  in  1  pixel clock.
REQ-007 rst  in  1  reset; reset is synchronous and active-high.
REQ-008 x  in  11  column from timing generator.
REQ-009 y  in  11  row from timing generator.
REQ-010 hsync_in  in  1  active-low hsync from timing generator.
REQ-011 vsync_in  in  1  active-low vsync from timing generator.
REQ-012 run  in  1  high = box moves; low = box frozen.
REQ-013 hsync  out  1  hsync_in delayed to align with rgb.
REQ-014 vsync  out  1  vsync_in delayed to align with rgb.
REQ-015 r, g, b  out  4 each  pixel colour.

Function
REQ-016 rgb, hsync and vsync SHALL all be registered with exactly 2 clk of latency from x/y/hsync_in/vsync_in.
REQ-017 Stage 1 SHALL register active = (x < WIDTH && y < HEIGHT) and inside = (box_x <= x < box_x+BOX_SIZE && box_y <= y < box_y+BOX_SIZE); stage 2 SHALL select colour.
REQ-018 Output colour SHALL be 0 when !active, palette[color_idx] when inside, else BG_RGB.
REQ-019 Frame tick SHALL be the vsync_in falling edge (registered vsync_prev==1 && vsync_in==0); exactly one tick per frame.
REQ-020 On a tick with run=1, each axis SHALL update once; with run=0, position, direction and color_idx SHALL hold.
REQ-021 X moving right: if box_x + STEP >= WIDTH - BOX_SIZE then box_x <= WIDTH-BOX_SIZE and dir_x <= left, else box_x <= box_x + STEP.
REQ-022 X moving left: if box_x <= STEP then box_x <= 0 and dir_x <= right, else box_x <= box_x - STEP; Y axis identical with HEIGHT, down/up.
REQ-023 color_idx (3 bits) SHALL increment modulo 8 on a tick where either axis bounces; a simultaneous X and Y bounce (corner) SHALL increment once.
REQ-024 Palette SHALL be 8 fixed entries: red, green, blue, yellow, cyan, magenta, white, orange (12'hF00,0F0,00F,FF0,0FF,F0F,FFF,F80).
REQ-025 Arithmetic on box_x/box_y SHALL use 11-bit unsigned values with no wrap; position SHALL always satisfy 0 <= box_x <= WIDTH-BOX_SIZE.
REQ-026 Position changes SHALL take effect only at the tick, so a frame never renders a torn box.

Reset
REQ-027 On rst: box_x=0, box_y=0, dir right/down, color_idx=0, vsync_prev=1, pipeline rgb=0, hsync=1, vsync=1.
REQ-028 rst asserted mid-frame SHALL take effect on the next clk edge; first tick after release follows REQ-019 normally.

Configuration
REQ-029 Macro BOUNCE_BORDER_EN defined: active pixels with x==0, x==WIDTH-1, y==0 or y==HEIGHT-1 and not inside SHALL be 12'hFFF.
REQ-030 BOUNCE_BORDER_EN undefined: no border logic; REQ-018 alone applies.

Structure
REQ-031 Shared package vga_pkg SHALL hold 800x600 timing constants, the rgb12_t typedef and the palette constant array.
REQ-032 A sub-module vga_sync_delay (parameterised depth, default 2, reset value 1) SHALL delay hsync/vsync.

Verification
REQ-033 Reset, then drive x=0..15,y=0 -> 2 cycles later rgb=12'hF00 (box at 0,0), hsync=vsync=1 during reset.
REQ-034 Drive x=900,y=10 -> rgb=0 two cycles later; hsync_in pulse appears on hsync exactly 2 cycles delayed.
REQ-035 Run 10 frames, run=1 -> box_x=box_y=20; run=0 for 5 frames -> unchanged.
REQ-036 Preload box_x=766 moving right, tick -> box_x=768, dir left, color_idx 0->1.
REQ-037 Corner: box_x=768, box_y=568 both moving outward, tick -> both directions flip, color_idx increments by exactly 1.
REQ-038 BOUNCE_BORDER_EN defined: x=799,y=300 -> 12'hFFF; undefined -> BG_RGB.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: 800x600 timing constants, 12-bit colour type, bounce palette
// and the per-axis bounce step used by vga_bounce_box.
package vga_pkg;

   // 800x600 @ 60 Hz, 40 MHz pixel clock
   localparam int unsigned H_ACTIVE = 800;
   localparam int unsigned H_FRONT  = 40;
   localparam int unsigned H_SYNC   = 128;
   localparam int unsigned H_BACK   = 88;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_ACTIVE = 600;
   localparam int unsigned V_FRONT  = 1;
   localparam int unsigned V_SYNC   = 4;
   localparam int unsigned V_BACK   = 23;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   typedef logic [11:0] rgb12_t;

   localparam rgb12_t PALETTE [8] = '{
      12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
      12'h0FF, 12'hF0F, 12'hFFF, 12'hF80
   };

   // DirFwd is right/down, DirBack is left/up
   typedef enum logic {DirFwd = 1'b0, DirBack = 1'b1} dir_e;

   typedef struct packed {
      logic [10:0] pos;
      dir_e        dir;
   } axis_t;

   typedef struct packed {
      axis_t axis;
      logic  bounce;
   } axis_upd_t;

   // One frame of motion on one axis; lim is the largest legal position.
   function automatic axis_upd_t axis_next(input axis_t cur, input logic [10:0] lim,
                                           input logic [10:0] step);
      axis_upd_t   res;
      logic [11:0] sum;
      res.axis   = cur;
      res.bounce = 1'b0;
      sum        = {1'b0, cur.pos} + {1'b0, step};
      if (cur.dir == DirFwd) begin
         if (sum >= {1'b0, lim}) begin
            res.axis.pos = lim;
            res.axis.dir = DirBack;
            res.bounce   = 1'b1;
         end else begin
            res.axis.pos = sum[10:0];
         end
      end else begin
         if (cur.pos <= step) begin
            res.axis.pos = 11'd0;
            res.axis.dir = DirFwd;
            res.bounce   = 1'b1;
         end else begin
            res.axis.pos = cur.pos - step;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register for sync signals; every stage resets to 1 (sync inactive).
module vga_sync_delay #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned BITS  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] din,
   output logic [BITS-1:0] dout
);

   logic [BITS-1:0] pipe_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '1;
      end else begin
         pipe_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_bounce_box.sv
// Bouncing box overlay for a VGA timing stream; 2-cycle pixel pipeline, box moves on vsync.
// Optional white screen border enabled by defining BOUNCE_BORDER_EN.
module vga_bounce_box
   import vga_pkg::*;
#(
   parameter int unsigned WIDTH    = H_ACTIVE,
   parameter int unsigned HEIGHT   = V_ACTIVE,
   parameter int unsigned BOX_SIZE = 32,
   parameter int unsigned STEP     = 2,
   parameter rgb12_t      BG_RGB   = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        run,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b
);

   localparam logic [10:0] X_MAX  = 11'(WIDTH - BOX_SIZE);
   localparam logic [10:0] Y_MAX  = 11'(HEIGHT - BOX_SIZE);
   localparam logic [10:0] STEP_V = 11'(STEP);

   axis_t       ax_q, ay_q;
   logic [2:0]  color_idx_q;
   logic        vsync_prev_q;
   logic        tick;
   axis_upd_t   nx, ny;

   assign tick = vsync_prev_q & ~vsync_in;

   always_comb begin
      nx = axis_next(ax_q, X_MAX, STEP_V);
      ny = axis_next(ay_q, Y_MAX, STEP_V);
   end

   // Motion state only changes on the frame tick, so a frame never shows a torn box.
   always_ff @(posedge clk) begin
      if (rst) begin
         ax_q         <= '{pos: 11'd0, dir: DirFwd};
         ay_q         <= '{pos: 11'd0, dir: DirFwd};
         color_idx_q  <= 3'd0;
         vsync_prev_q <= 1'b1;
      end else begin
         vsync_prev_q <= vsync_in;
         if (tick && run) begin
            ax_q <= nx.axis;
            ay_q <= ny.axis;
            if (nx.bounce || ny.bounce) color_idx_q <= color_idx_q + 3'd1;
         end
      end
   end

   // Stage 1: classify the pixel.
   logic [11:0] x_w, y_w, x_end, y_end;
   logic        active_d, inside_d;
   logic        active_q, inside_q;

   always_comb begin
      x_w      = {1'b0, x};
      y_w      = {1'b0, y};
      x_end    = {1'b0, ax_q.pos} + 12'(BOX_SIZE);
      y_end    = {1'b0, ay_q.pos} + 12'(BOX_SIZE);
      active_d = (x_w < 12'(WIDTH)) && (y_w < 12'(HEIGHT));
      inside_d = (x >= ax_q.pos) && (x_w < x_end) && (y >= ay_q.pos) && (y_w < y_end);
   end

`ifdef BOUNCE_BORDER_EN
   logic border_d, border_q;
   assign border_d = (x == 11'd0) || (x_w == 12'(WIDTH - 1)) ||
                     (y == 11'd0) || (y_w == 12'(HEIGHT - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         inside_q <= 1'b0;
`ifdef BOUNCE_BORDER_EN
         border_q <= 1'b0;
`endif
      end else begin
         active_q <= active_d;
         inside_q <= inside_d;
`ifdef BOUNCE_BORDER_EN
         border_q <= border_d;
`endif
      end
   end

   // Stage 2: colour select.
   rgb12_t pix_d, rgb_q;

   always_comb begin
      pix_d = BG_RGB;
      if (!active_q) begin
         pix_d = 12'h000;
      end else if (inside_q) begin
         pix_d = PALETTE[color_idx_q];
`ifdef BOUNCE_BORDER_EN
      end else if (border_q) begin
         pix_d = 12'hFFF;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rgb_q <= 12'h000;
      else     rgb_q <= pix_d;
   end

   assign r = rgb_q[11:8];
   assign g = rgb_q[7:4];
   assign b = rgb_q[3:0];

   logic [1:0] sync_out;

   vga_sync_delay #(
      .DEPTH (2),
      .BITS  (2)
   ) u_sync_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({hsync_in, vsync_in}),
      .dout (sync_out)
   );

   assign hsync = sync_out[1];
   assign vsync = sync_out[0];

endmodule
